// File: rtl/key_scan_pkg.sv
// key_scan_pkg
// Shared types and helpers for the 4x4 keypad scanner.
//   key_state_e   : debounce FSM states (IDLE, DEBOUNCE, HELD)
//   N_ROWS/N_COLS : matrix geometry; N_KEYS = one frame bit per key
//   popcount16    : number of set bits in a 16-bit frame
//   onehot_index  : index of the set bit in a one-hot frame (col*4 + row)
package key_scan_pkg;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int N_KEYS = N_ROWS * N_COLS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } key_state_e;

  function automatic logic [4:0] popcount16(input logic [N_KEYS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [3:0] onehot_index(input logic [N_KEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm
// Frame-level debouncer: compares each completed key frame with the previous one,
// counts consecutive identical frames and accepts single-key presses/releases.
// Ports:
//   i_clk        : system clock
//   i_rst_n      : synchronous active-low reset
//   i_frame      : completed 16-bit key frame, bit col*4+row = key pressed
//   i_frame_end  : one-cycle strobe, i_frame is complete this cycle
//   o_key_code   : code of last accepted key
//   o_key_valid  : one-cycle pulse on an accepted press
//   o_key_down   : high while the accepted key is held
module key_debounce_fsm
  import key_scan_pkg::*;
#(
  parameter logic [7:0] DB_FRAMES = 8'd5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_frame,
  input  logic              i_frame_end,
  output logic [3:0]        o_key_code,
  output logic              o_key_valid,
  output logic              o_key_down
);

  key_state_e        r_state, w_state_next;
  logic [N_KEYS-1:0] r_prev;
  logic [7:0]        r_stable_cnt, w_cnt_next;
  logic [3:0]        r_key_code, w_key_code_next;
  logic              r_key_valid, w_key_valid_next;
  logic              r_key_down, w_key_down_next;
  logic              w_same, w_one_key, w_stable;

  assign w_same    = (i_frame == r_prev);
  assign w_one_key = (popcount16(i_frame) == 5'd1);

  // Stability count as it will be after this frame end; decisions use the
  // updated value so the frame just completed counts toward debounce.
  always_comb begin
    w_cnt_next = '0;
    if (w_same) begin
      w_cnt_next = (r_stable_cnt >= DB_FRAMES) ? DB_FRAMES : r_stable_cnt + 8'd1;
    end
  end

  assign w_stable = (w_cnt_next >= DB_FRAMES);

  always_comb begin
    w_state_next     = r_state;
    w_key_code_next  = r_key_code;
    w_key_valid_next = 1'b0;
    w_key_down_next  = r_key_down;
    if (i_frame_end) begin
      unique case (r_state)
        IDLE: begin
          if (w_one_key) begin
            w_state_next = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!w_same || !w_one_key) begin
            w_state_next = IDLE;
          end else if (w_stable) begin
            w_key_code_next  = onehot_index(i_frame);
            w_key_valid_next = 1'b1;
            w_key_down_next  = 1'b1;
            w_state_next     = HELD;
          end
        end
        HELD: begin
          // Additional keys while held are ignored; only a stable empty frame
          // releases.
          if ((i_frame == '0) && w_stable) begin
            w_key_down_next = 1'b0;
            w_state_next    = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_stable_cnt <= '0;
      r_key_code   <= 4'h0;
      r_key_valid  <= 1'b0;
      r_key_down   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_key_code  <= w_key_code_next;
      r_key_valid <= w_key_valid_next;
      r_key_down  <= w_key_down_next;
      if (i_frame_end) begin
        r_prev       <= i_frame;
        r_stable_cnt <= w_cnt_next;
      end
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_down  = r_key_down;

endmodule

// File: rtl/key_scan_module.sv
// key_scan_module
// 4x4 matrix keypad reader: strobes one column per dwell period, samples the
// synchronized rows at the end of each dwell and assembles a 16-bit key frame
// that is debounced by key_debounce_fsm.
// Ports:
//   CLK       : system clock
//   RSTn      : synchronous active-low reset
//   Row_Sig   : keypad rows, active-low, asynchronous to CLK
//   Col_Sig   : column strobes, active-low one-hot, registered
//   Key_Code  : code of last accepted key (col*4 + row)
//   Key_Valid : one-cycle pulse on a newly accepted press
//   Key_Down  : high while the accepted key is held
module key_scan_module
  import key_scan_pkg::*;
#(
  parameter logic [15:0] T1MS      = 16'd49999,
  parameter logic [7:0]  DB_FRAMES = 8'd5
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [N_ROWS-1:0] Row_Sig,
  output logic [N_COLS-1:0] Col_Sig,
  output logic [3:0]        Key_Code,
  output logic              Key_Valid,
  output logic              Key_Down
);

  logic [15:0]       r_c1;
  logic [1:0]        r_col;
  logic [N_COLS-1:0] r_col_sig;
  logic [N_ROWS-1:0] r_row_meta, r_row_sync;
  logic [N_KEYS-1:0] r_frame;

  logic              w_tick, w_frame_end;
  logic [1:0]        w_col_next;
  logic [N_KEYS-1:0] w_frame_full;

  assign w_tick      = (r_c1 == T1MS);
  assign w_frame_end = w_tick && (r_col == 2'(N_COLS - 1));
  assign w_col_next  = r_col + 2'd1;

  // Frame with the current column's sample merged in, so the frame-end compare
  // sees the last column taken on that same tick.
  always_comb begin
    w_frame_full = r_frame;
    w_frame_full[r_col * N_ROWS +: N_ROWS] = ~r_row_sync;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_c1       <= '0;
      r_col      <= '0;
      r_col_sig  <= 4'b1110;
      r_row_meta <= 4'b1111;
      r_row_sync <= 4'b1111;
      r_frame    <= '0;
    end else begin
      r_row_meta <= Row_Sig;
      r_row_sync <= r_row_meta;
      if (w_tick) begin
        r_c1      <= '0;
        r_col     <= w_col_next;
        r_col_sig <= ~(4'b0001 << w_col_next);
        r_frame   <= w_frame_full;
      end else begin
        r_c1 <= r_c1 + 16'd1;
      end
    end
  end

  key_debounce_fsm #(
    .DB_FRAMES(DB_FRAMES)
  ) u_debounce (
    .i_clk      (CLK),
    .i_rst_n    (RSTn),
    .i_frame    (w_frame_full),
    .i_frame_end(w_frame_end),
    .o_key_code (Key_Code),
    .o_key_valid(Key_Valid),
    .o_key_down (Key_Down)
  );

  assign Col_Sig = r_col_sig;

endmodule
